// File: rtl/imem_burst.sv
// imem_burst: block-refill engine between the I-cache miss port and a
// fixed-latency synchronous instruction RAM. One accepted request produces
// BLOCK_SIZE RAM reads in ascending address order and returns the words
// as contiguous single-cycle mem_val beats. The request/teardown handshake
// guarantees that a level request is served exactly once.
module imem_burst #(
    parameter int BLOCK_SIZE  = 8,
    parameter int WAIT_CYCLES = 4,
    parameter int RAM_LAT     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_val,
    output logic        ram_en,
    output logic [31:0] ram_addr,
    input  logic [31:0] ram_rdata,
    output logic        busy
);
    localparam int IDX_W = $clog2(BLOCK_SIZE);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [3:0]       WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BLOCK_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [31:0]      BASE_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [RAM_LAT-1:0] PIPE_ZERO = {RAM_LAT{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         wait_q, wait_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        base_q, base_d;
    logic [RAM_LAT-1:0] vpipe_q, vpipe_d;
    logic               ram_en_q, ram_en_d;
    logic [31:0]        ram_addr_q, ram_addr_d;
    logic               mem_val_q, mem_val_d;
    logic [31:0]        mem_data_q, mem_data_d;
    logic               busy_q, busy_d;

    // State register plus burst bookkeeping (base, wait and issue counters).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
            idx_q   <= IDX_ZERO;
            base_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
        end
    end

    // Next-state logic: accept, wait out the idle gap, issue the block, drain, tear down.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        base_d  = base_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    base_d = mem_addr & BASE_MASK;
                    wait_d = WAIT_INIT;
                    idx_d  = IDX_ZERO;
                    if (WAIT_INIT == 4'd0) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ISSUE: begin
                // Index wraps inside the block so the tag bits never change.
                idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                if (idx_q == IDX_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: begin
                // Empty valid pipe means the final word is on mem_data this cycle.
                if (vpipe_q == PIPE_ZERO) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                // A request still held high here was already served; wait for it to drop.
                if (!mem_req) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: RAM strobe/address follow the next state so they are registered,
    // and the valid pipe tracks each read until its data returns.
    always_comb begin
        ram_en_d   = 1'b0;
        ram_addr_d = 32'd0;
        vpipe_d    = PIPE_ZERO;
        mem_val_d  = 1'b0;
        mem_data_d = 32'd0;
        busy_d     = 1'b0;
        if (state_d == S_ISSUE) begin
            ram_en_d   = 1'b1;
            ram_addr_d = base_d | {{(30-IDX_W){1'b0}}, idx_d, 2'b00};
        end else begin
            ram_en_d   = 1'b0;
            ram_addr_d = 32'd0;
        end
        vpipe_d[0] = ram_en_q;
        for (int i = 1; i < RAM_LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
        mem_val_d = vpipe_q[RAM_LAT-1];
        if (mem_val_d) begin
            mem_data_d = ram_rdata;
        end else begin
            mem_data_d = 32'd0;
        end
        busy_d = (state_d != S_IDLE);
    end

    // Output registers and valid pipeline; reset drops every strobe immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vpipe_q    <= PIPE_ZERO;
            ram_en_q   <= 1'b0;
            ram_addr_q <= 32'd0;
            mem_val_q  <= 1'b0;
            mem_data_q <= 32'd0;
            busy_q     <= 1'b0;
        end else begin
            vpipe_q    <= vpipe_d;
            ram_en_q   <= ram_en_d;
            ram_addr_q <= ram_addr_d;
            mem_val_q  <= mem_val_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
        end
    end

    assign ram_en   = ram_en_q;
    assign ram_addr = ram_addr_q;
    assign mem_val  = mem_val_q;
    assign mem_data = mem_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_imem_burst.sv
// Directed bench for imem_burst: default-parameter instance checked cycle by
// cycle, plus a set of instances sweeping WAIT_CYCLES/RAM_LAT for beat timing.
module tb_imem_burst;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_req = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_data, ram_addr, ram_rdata;
    logic        mem_val, ram_en, busy;
    logic [31:0] ra_q;

    int total = 0;
    int fails = 0;
    int cyc = 0;
    int acc = 0;

    always #5 clk = ~clk;

    // cycle counter: value during a cycle equals number of rising edges seen
    always @(posedge clk) cyc <= cyc + 1;

    imem_burst u_dut (
        .clk(clk), .reset(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_val(mem_val), .ram_en(ram_en),
        .ram_addr(ram_addr), .ram_rdata(ram_rdata), .busy(busy)
    );

    // RAM model, latency 1: word n holds 0x1000_0000 + n
    always @(posedge clk) ra_q <= ram_addr;
    assign ram_rdata = 32'h1000_0000 + (ra_q >> 2);

    // ---------------- sweep instances ----------------
    localparam int NSW = 6;
    function automatic int sw_w(input int k);
        case (k)
            0, 1, 2, 3: return 0;
            default:    return 15;
        endcase
    endfunction
    function automatic int sw_l(input int k);
        case (k)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 4;
            4: return 1;
            default: return 4;
        endcase
    endfunction

    logic        sw_req = 1'b0;
    logic [31:0] sw_addr = 32'd0;
    wire  [31:0] sw_n     [NSW];
    wire  [31:0] sw_first [NSW];
    wire         sw_contig[NSW];
    wire         sw_dok   [NSW];
    wire         sw_busy  [NSW];

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        localparam int W = sw_w(g);
        localparam int L = sw_l(g);
        logic [31:0] d, ra, rd;
        logic        v, en, b;
        logic [31:0] pa [4];
        int   n = 0;
        int   first = 0;
        int   last = 0;
        logic contig = 1'b1;
        logic dok = 1'b1;

        imem_burst #(.BLOCK_SIZE(8), .WAIT_CYCLES(W), .RAM_LAT(L)) u_sw (
            .clk(clk), .reset(rst_n), .mem_req(sw_req), .mem_addr(sw_addr),
            .mem_data(d), .mem_val(v), .ram_en(en), .ram_addr(ra),
            .ram_rdata(rd), .busy(b)
        );

        // RAM model with latency L
        always @(posedge clk) begin
            pa[0] <= ra;
            for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
        end
        assign rd = 32'h1000_0000 + (pa[L-1] >> 2);

        // beat logger: first beat cycle, contiguity, data order
        always @(negedge clk) begin
            if (v) begin
                if (n == 0) first <= cyc;
                else if (cyc != last + 1) contig <= 1'b0;
                if (d !== 32'h1000_0080 + 32'(n)) dok <= 1'b0;
                last <= cyc;
                n <= n + 1;
            end
        end

        assign sw_n[g]      = 32'(n);
        assign sw_first[g]  = 32'(first);
        assign sw_contig[g] = contig;
        assign sw_dok[g]    = dok;
        assign sw_busy[g]   = b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One burst on the default instance (W=4, B=8, L=1), starting in the current
    // cycle (cycle 0). drop_at = cycle in which mem_req is driven low.
    task automatic burst(input logic [31:0] addr, input logic [31:0] base,
                         input logic [31:0] word0, input int drop_at, input int last_c);
        int beats = 0;
        int idle_c;
        idle_c = (drop_at > 15) ? drop_at + 1 : 16;
        mem_req  = 1'b1;
        mem_addr = addr;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            check("ram_en", 32'(ram_en), (c >= 5 && c <= 12) ? 32'd1 : 32'd0);
            check("ram_addr", ram_addr, (c >= 5 && c <= 12) ? base + 32'(4 * (c - 5)) : 32'd0);
            check("mem_val", 32'(mem_val), (c >= 7 && c <= 14) ? 32'd1 : 32'd0);
            check("mem_data", mem_data, (c >= 7 && c <= 14) ? word0 + 32'(c - 7) : 32'd0);
            check("busy", 32'(busy), (c < idle_c) ? 32'd1 : 32'd0);
            if (mem_val) beats++;
            if (c == 2) mem_addr = ~addr;
            if (c == drop_at) mem_req = 1'b0;
        end
        check("beats", 32'(beats), 32'd8);
    endtask

    initial begin
        // reset state
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_val", 32'(mem_val), 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic burst, request held 10 cycles past last beat, dropped in cycle 25
        burst(32'h0000_0044, 32'h0000_0040, 32'h1000_0010, 25, 26);

        // back-to-back: request one cycle after IDLE re-entry
        @(negedge clk);
        burst(32'h0000_0100, 32'h0000_0100, 32'h1000_0040, 16, 17);

        // request dropped in WAIT: full burst, then IDLE straight after DONE
        burst(32'h0000_0084, 32'h0000_0080, 32'h1000_0020, 3, 17);

        // asynchronous reset mid-stream (cycle 9)
        mem_req  = 1'b1;
        mem_addr = 32'h0000_0044;
        repeat (9) @(negedge clk);
        check("pre_rst_ram_en", 32'(ram_en), 32'd1);
        check("pre_rst_mem_val", 32'(mem_val), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_val", 32'(mem_val), 32'd0);
        check("arst_mem_data", mem_data, 32'd0);
        check("arst_ram_en", 32'(ram_en), 32'd0);
        check("arst_ram_addr", ram_addr, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        mem_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("post_rst_mem_val", 32'(mem_val), 32'd0);
            check("post_rst_ram_en", 32'(ram_en), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end
        burst(32'h0000_0044, 32'h0000_0040, 32'h1000_0010, 16, 17);

        // parameter sweep: one request to all sweep instances
        sw_req  = 1'b1;
        sw_addr = 32'h0000_021C;
        acc     = cyc;
        repeat (45) @(negedge clk);
        sw_req = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NSW; k++) begin
            check("sw_beats", sw_n[k], 32'd8);
            check("sw_first", sw_first[k], 32'(acc + sw_w(k) + sw_l(k) + 2));
            check("sw_contig", 32'(sw_contig[k]), 32'd1);
            check("sw_data", 32'(sw_dok[k]), 32'd1);
            check("sw_busy", 32'(sw_busy[k]), 32'd0);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/imem_burst.md
# imem_burst

Instruction-memory burst engine sitting directly downstream of the instruction cache's miss port. It accepts a block refill request (`mem_req`, `mem_addr`), reads `BLOCK_SIZE` consecutive words from a fixed-latency synchronous instruction RAM, and returns them in ascending address order as single-cycle `mem_val` beats on `mem_data`. The cache counts beats and shifts words in itself; this block only guarantees order, count and request/teardown handshake.

## Interface
- `BLOCK_SIZE`, 8: words per burst; power of two, 2..16.
- `WAIT_CYCLES`, 4: idle cycles between accepting a request and the first RAM read; 0..15.
- `RAM_LAT`, 1: cycles from `ram_en` to valid `ram_rdata`; 1..4.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_req`  in  1  refill request from cache; level, held until cache has counted `BLOCK_SIZE` beats.
- `mem_addr`  in  32  block address; low log2(BLOCK_SIZE*4) bits ignored (forced to 0).
- `mem_data`  out  32  returned instruction word; 0 when `mem_val`=0.
- `mem_val`  out  1  one-cycle strobe per returned word.
- `ram_en`  out  1  RAM read enable.
- `ram_addr`  out  32  RAM byte address, word aligned.
- `ram_rdata`  in  32  RAM read data, valid `RAM_LAT` cycles after `ram_en`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, WAIT, ISSUE, DRAIN, DONE.
- IDLE: `mem_req`=1 at an edge → latch `base` = `mem_addr` with low block-offset bits cleared; go WAIT (or ISSUE if `WAIT_CYCLES`=0). Wait counter loaded with `WAIT_CYCLES`.
- WAIT: decrement counter each cycle; exactly `WAIT_CYCLES` cycles spent here, then ISSUE.
- ISSUE: `ram_en`=1 every cycle for exactly `BLOCK_SIZE` cycles; `ram_addr` = `base` + 4*i, i = 0..BLOCK_SIZE-1 (issue counter, wraps only within the block, no carry into tag bits). After the last issue → DRAIN.
- Valid pipeline: `RAM_LAT`-deep shift of `ram_en`; at its tail, register `ram_rdata` into `mem_data` and set `mem_val` for one cycle.
- DRAIN: stay until the valid pipeline is empty and the final beat has been driven; then DONE.
- DONE: stay while `mem_req`=1; on `mem_req`=0 → IDLE. A request held high after the last beat is never re-served; a new burst requires `mem_req` low for ≥1 sampled edge.
- `mem_req` dropping during WAIT/ISSUE/DRAIN: no abort; burst completes all `BLOCK_SIZE` beats, then DONE sees low → IDLE.
- `mem_addr` changes after acceptance are ignored until next IDLE acceptance.
- `ram_en`=0 and `ram_addr`=0 outside ISSUE.
- Reset (`reset`=0, any time incl. mid-burst): immediately state IDLE, all counters and valid pipeline cleared, `mem_val`=0, `mem_data`=0, `ram_en`=0, `ram_addr`=0, `busy`=0. No partial beats after release.

## Timing
- Cycle 0 = cycle in which `mem_req` is first sampled high in IDLE; cycle 1 is the first cycle after that edge.
- WAIT: cycles 1..W (W=`WAIT_CYCLES`). `ram_en`: cycles W+1..W+B (B=`BLOCK_SIZE`).
- Beat i (word at `base`+4i): `mem_val` in cycle W+1+i+RAM_LAT+1. Beats contiguous, no gaps.
- Defaults (W=4, B=8, L=1): `ram_en` cycles 5–12, `mem_val` cycles 7–14. Cache sees count=8 in cycle 15, drops `mem_req` in cycle 16; DONE→IDLE at end of 16; new request accepted no earlier than end of cycle 17.
- `busy` high cycles 1 through last DONE cycle.
- Throughput: one word/cycle once streaming; per-burst overhead W+L+1 cycles plus teardown.

## Test plan
- Defaults, RAM word n = 0x1000_0000+n, `mem_req`=1 with `mem_addr`=0x0000_0044 → `ram_addr` 0x40..0x5C in cycles 5–12; `mem_val` cycles 7–14 with `mem_data` 0x1000_0010..0x1000_0017; exactly 8 beats.
- Hold `mem_req`=1 for 10 cycles after last beat → no further `ram_en`/`mem_val`; `busy`=1 until `mem_req` drops, then 0 next cycle.
- Back-to-back: second request `mem_addr`=0x0000_0100 one cycle after IDLE re-entry → second burst starts, `ram_addr` 0x100..0x11C, data in ascending order.
- Sweep `RAM_LAT`=1..4, `WAIT_CYCLES`=0 and 15 → first `mem_val` at cycle W+L+2, 8 contiguous beats, correct data.
- Drop `mem_req` in cycle 3 (WAIT) → full 8 beats still delivered, then IDLE without DONE stall.
- Assert `reset`=0 asynchronously in cycle 9 (mid-stream) → `mem_val`, `ram_en`, `busy` go 0 without a clock edge; after release with `mem_req`=0 no beats appear; next request serves a full fresh burst.
